// File: rtl/parking_pkg.sv
// Shared types, width helpers and default sizing for the parking gate arbiter.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        CLOSE = 2'd2
    } gate_state_t;

    localparam int unsigned DEF_NUM_SPOTS    = 4;
    localparam int unsigned DEF_N_ENTRY      = 2;
    localparam int unsigned DEF_N_EXIT       = 2;
    localparam int unsigned DEF_OPEN_CYCLES  = 8;
    localparam int unsigned DEF_CLOSE_CYCLES = 2;

    // Bits needed to index n slots (at least one).
    function automatic int unsigned slot_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to hold a count from 0 to n inclusive (at least one).
    function automatic int unsigned cap_width(input int unsigned n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

    // Round-robin pointer width for w requesters.
    function automatic int unsigned ptr_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/parking_gate_arbiter_rr_arbiter.sv
// Round-robin arbiter: first request at or after the pointer, searching modulo W.
module rr_arbiter
    import parking_pkg::*;
#(
    parameter  int unsigned W  = 4,
    localparam int unsigned PW = ptr_width(W)
) (
    input  logic [W-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [W-1:0]  o_gnt,
    output logic          o_valid,
    output logic [PW-1:0] o_next_ptr
);

    int unsigned w_idx;

    always_comb begin
        o_gnt      = '0;
        o_valid    = 1'b0;
        o_next_ptr = i_ptr;
        w_idx      = 0;
        for (int unsigned k = 0; k < W; k++) begin
            w_idx = (32'(i_ptr) + k) % W;
            if (!o_valid && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_valid      = 1'b1;
                o_next_ptr   = PW'((w_idx + 1) % W);
            end
        end
    end

endmodule

// File: rtl/parking_gate_arbiter.sv
// Shares one barrier gate and the slot pool among entry/exit lanes.
// Build macro EXIT_PRIORITY_EN: pending exits beat entries, each group with its own pointer.
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter  int unsigned NUM_SPOTS    = DEF_NUM_SPOTS,
    parameter  int unsigned N_ENTRY      = DEF_N_ENTRY,
    parameter  int unsigned N_EXIT       = DEF_N_EXIT,
    parameter  int unsigned OPEN_CYCLES  = DEF_OPEN_CYCLES,
    parameter  int unsigned CLOSE_CYCLES = DEF_CLOSE_CYCLES,
    localparam int unsigned R            = N_ENTRY + N_EXIT,
    localparam int unsigned SLOT_W       = slot_width(NUM_SPOTS),
    localparam int unsigned CAP_W        = cap_width(NUM_SPOTS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_ENTRY-1:0]       entry_req,
    input  logic [N_EXIT-1:0]        exit_req,
    input  logic [N_EXIT*SLOT_W-1:0] exit_slot,
    input  logic                     gate_clear,
    output logic [R-1:0]             grant,
    output logic [R-1:0]             reject,
    output logic [SLOT_W-1:0]        assigned_slot,
    output logic                     gate_open,
    output logic                     timeout,
    output logic [NUM_SPOTS-1:0]     spots,
    output logic [CAP_W-1:0]         capacity,
    output logic                     full
);

    localparam int unsigned TMR_W = cap_width(OPEN_CYCLES);
    localparam int unsigned CLS_W = cap_width(CLOSE_CYCLES);

    gate_state_t          r_state;
    logic [R-1:0]         r_grant;
    logic [R-1:0]         r_reject;
    logic [SLOT_W-1:0]    r_assigned;
    logic                 r_gate_open;
    logic                 r_timeout;
    logic [NUM_SPOTS-1:0] r_spots;
    logic [CAP_W-1:0]     r_capacity;
    logic                 r_full;
    logic [TMR_W-1:0]     r_timer;
    logic [CLS_W-1:0]     r_close_cnt;
    logic                 r_was_entry;

    logic [R-1:0]         w_win;
    logic                 w_valid;
    logic                 w_is_entry;
    logic                 w_accept;
    logic [SLOT_W-1:0]    w_free_slot;
    logic [SLOT_W-1:0]    w_sel_slot;
    logic [CAP_W-1:0]     w_cap_inc;
    logic [CAP_W-1:0]     w_cap_dec;

`ifdef EXIT_PRIORITY_EN
    localparam int unsigned EPW = ptr_width(N_ENTRY);
    localparam int unsigned XPW = ptr_width(N_EXIT);

    logic [EPW-1:0]     r_ent_ptr;
    logic [XPW-1:0]     r_ext_ptr;
    logic [EPW-1:0]     w_ent_next;
    logic [XPW-1:0]     w_ext_next;
    logic [N_ENTRY-1:0] w_ent_win;
    logic [N_EXIT-1:0]  w_ext_win;
    logic               w_ent_valid;
    logic               w_ext_valid;

    rr_arbiter #(.W(N_ENTRY)) u_rr_entry (
        .i_req      (entry_req),
        .i_ptr      (r_ent_ptr),
        .o_gnt      (w_ent_win),
        .o_valid    (w_ent_valid),
        .o_next_ptr (w_ent_next)
    );

    rr_arbiter #(.W(N_EXIT)) u_rr_exit (
        .i_req      (exit_req),
        .i_ptr      (r_ext_ptr),
        .o_gnt      (w_ext_win),
        .o_valid    (w_ext_valid),
        .o_next_ptr (w_ext_next)
    );

    assign w_valid = w_ent_valid | w_ext_valid;
    assign w_win   = w_ext_valid ? {w_ext_win, {N_ENTRY{1'b0}}} : {{N_EXIT{1'b0}}, w_ent_win};
`else
    localparam int unsigned PW = ptr_width(R);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_next_ptr;

    rr_arbiter #(.W(R)) u_rr (
        .i_req      ({exit_req, entry_req}),
        .i_ptr      (r_ptr),
        .o_gnt      (w_win),
        .o_valid    (w_valid),
        .o_next_ptr (w_next_ptr)
    );
`endif

    // Lowest-index free slot and the slot named by the winning exit lane.
    always_comb begin
        w_free_slot = '0;
        for (int i = int'(NUM_SPOTS) - 1; i >= 0; i--) begin
            if (!r_spots[i]) w_free_slot = SLOT_W'(i);
        end
        w_sel_slot = '0;
        for (int unsigned j = 0; j < N_EXIT; j++) begin
            if (w_win[N_ENTRY + j]) w_sel_slot = exit_slot[j*SLOT_W +: SLOT_W];
        end
    end

    assign w_is_entry = |w_win[N_ENTRY-1:0];
    assign w_accept   = w_is_entry ? (r_capacity != '0) : r_spots[w_sel_slot];
    assign w_cap_inc  = r_capacity + CAP_W'(1);
    assign w_cap_dec  = r_capacity - CAP_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_reject    <= '0;
            r_assigned  <= '0;
            r_gate_open <= 1'b0;
            r_timeout   <= 1'b0;
            r_spots     <= '0;
            r_capacity  <= CAP_W'(NUM_SPOTS);
            r_full      <= 1'b0;
            r_timer     <= '0;
            r_close_cnt <= '0;
            r_was_entry <= 1'b0;
`ifdef EXIT_PRIORITY_EN
            r_ent_ptr   <= '0;
            r_ext_ptr   <= '0;
`else
            r_ptr       <= '0;
`endif
        end else begin
            r_grant   <= '0;
            r_reject  <= '0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        if (w_accept) begin
                            r_grant     <= w_win;
                            r_state     <= OPEN;
                            r_gate_open <= 1'b1;
                            r_timer     <= TMR_W'(OPEN_CYCLES);
                            r_was_entry <= w_is_entry;
                            if (w_is_entry) begin
                                r_spots[w_free_slot] <= 1'b1;
                                r_capacity           <= w_cap_dec;
                                r_full               <= (w_cap_dec == '0);
                                r_assigned           <= w_free_slot;
                            end else begin
                                r_spots[w_sel_slot] <= 1'b0;
                                r_capacity          <= w_cap_inc;
                                r_full              <= 1'b0;
                                r_assigned          <= w_sel_slot;
                            end
                        end else begin
                            r_reject <= w_win;
                        end
`ifdef EXIT_PRIORITY_EN
                        if (w_ext_valid) r_ext_ptr <= w_ext_next;
                        else             r_ent_ptr <= w_ent_next;
`else
                        r_ptr <= w_next_ptr;
`endif
                    end
                end
                OPEN: begin
                    // A clear on the expiry edge wins, so no rollback then.
                    if (gate_clear) begin
                        r_state     <= CLOSE;
                        r_gate_open <= 1'b0;
                        r_close_cnt <= CLS_W'(CLOSE_CYCLES - 1);
                    end else if (r_timer == TMR_W'(1)) begin
                        r_state     <= CLOSE;
                        r_gate_open <= 1'b0;
                        r_close_cnt <= CLS_W'(CLOSE_CYCLES - 1);
                        r_timeout   <= 1'b1;
                        if (r_was_entry) begin
                            r_spots[r_assigned] <= 1'b0;
                            r_capacity          <= w_cap_inc;
                            r_full              <= 1'b0;
                        end else begin
                            r_spots[r_assigned] <= 1'b1;
                            r_capacity          <= w_cap_dec;
                            r_full              <= (w_cap_dec == '0);
                        end
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                CLOSE: begin
                    if (r_close_cnt == '0) r_state <= IDLE;
                    else                   r_close_cnt <= r_close_cnt - CLS_W'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant         = r_grant;
    assign reject        = r_reject;
    assign assigned_slot = r_assigned;
    assign gate_open     = r_gate_open;
    assign timeout       = r_timeout;
    assign spots         = r_spots;
    assign capacity      = r_capacity;
    assign full          = r_full;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Self-checking bench for parking_gate_arbiter: cycle model plus directed literal checks.
`timescale 1ns/1ps
module tb_parking_gate_arbiter;

    localparam int OPEN_C  = 8;
    localparam int CLOSE_C = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] entry_req;
    logic [1:0] exit_req;
    logic [3:0] exit_slot;
    logic       gate_clear;
    logic [3:0] grant;
    logic [3:0] reject;
    logic [1:0] assigned_slot;
    logic       gate_open;
    logic       timeout;
    logic [3:0] spots;
    logic [2:0] capacity;
    logic       full;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    parking_gate_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .entry_req     (entry_req),
        .exit_req      (exit_req),
        .exit_slot     (exit_slot),
        .gate_clear    (gate_clear),
        .grant         (grant),
        .reject        (reject),
        .assigned_slot (assigned_slot),
        .gate_open     (gate_open),
        .timeout       (timeout),
        .spots         (spots),
        .capacity      (capacity),
        .full          (full)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0=idle 1=open 2=close, occupancy as a bit set.
    bit       m_ready = 1'b0;
    int       m_phase, m_open_left, m_close_left;
    bit [3:0] m_spots, m_grant, m_reject;
    bit       m_timeout, m_last_entry;
    int       m_slot, m_ptr, m_eptr, m_xptr;

    always @(posedge clk) begin
        bit [3:0] req;
        int       win;
        int       s;
        req       = {exit_req, entry_req};
        m_grant   = '0;
        m_reject  = '0;
        m_timeout = 1'b0;
        if (!reset) begin
            m_ready = 1'b1; m_phase = 0; m_spots = '0; m_slot = 0;
            m_ptr = 0; m_eptr = 0; m_xptr = 0; m_last_entry = 1'b0;
        end else if (m_phase == 0) begin
            win = -1;
`ifdef EXIT_PRIORITY_EN
            for (int i = 0; i < 2; i++)
                if (win < 0 && req[2 + (m_xptr + i) % 2]) win = 2 + (m_xptr + i) % 2;
            if (win >= 0) m_xptr = (win - 1) % 2;
            else begin
                for (int i = 0; i < 2; i++)
                    if (win < 0 && req[(m_eptr + i) % 2]) win = (m_eptr + i) % 2;
                if (win >= 0) m_eptr = (win + 1) % 2;
            end
`else
            for (int i = 0; i < 4; i++)
                if (win < 0 && req[(m_ptr + i) % 4]) win = (m_ptr + i) % 4;
            if (win >= 0) m_ptr = (win + 1) % 4;
`endif
            if (win >= 0) begin
                if (win < 2) begin
                    if ($countones(m_spots) < 4) begin
                        s = -1;
                        for (int i = 0; i < 4; i++) if (s < 0 && !m_spots[i]) s = i;
                        m_spots[s] = 1'b1; m_slot = s; m_last_entry = 1'b1;
                        m_grant[win] = 1'b1; m_phase = 1; m_open_left = OPEN_C;
                    end else m_reject[win] = 1'b1;
                end else begin
                    s = int'((exit_slot >> (2 * (win - 2))) & 4'h3);
                    if (m_spots[s]) begin
                        m_spots[s] = 1'b0; m_slot = s; m_last_entry = 1'b0;
                        m_grant[win] = 1'b1; m_phase = 1; m_open_left = OPEN_C;
                    end else m_reject[win] = 1'b1;
                end
            end
        end else if (m_phase == 1) begin
            if (gate_clear) begin
                m_phase = 2; m_close_left = CLOSE_C;
            end else begin
                m_open_left--;
                if (m_open_left == 0) begin
                    m_timeout = 1'b1;
                    m_spots[m_slot] = !m_last_entry;
                    m_phase = 2; m_close_left = CLOSE_C;
                end
            end
        end else begin
            m_close_left--;
            if (m_close_left == 0) m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            chk("grant",     32'(grant),         32'(m_grant));
            chk("reject",    32'(reject),        32'(m_reject));
            chk("timeout",   32'(timeout),       32'(m_timeout));
            chk("gate_open", 32'(gate_open),     32'(m_phase == 1));
            chk("slot",      32'(assigned_slot), 32'(m_slot));
            chk("spots",     32'(spots),         32'(m_spots));
            chk("capacity",  32'(capacity),      32'(4 - $countones(m_spots)));
            chk("full",      32'(full),          32'($countones(m_spots) == 4));
        end
    end

    // Snapshot taken on the cycle the ack is visible.
    logic [3:0] s_g, s_r, s_sp;
    logic [2:0] s_cap;
    logic [1:0] s_as;
    logic       s_go, s_fl;

    task automatic do_req(input int lane, input int slot, input int clear_delay);
        int n;
        if (lane < 2) entry_req[lane] = 1'b1;
        else begin
            exit_slot[(lane - 2) * 2 +: 2] = 2'(slot);
            exit_req[lane - 2] = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(grant[lane] | reject[lane]) && n < 60);
        s_g = grant; s_r = reject; s_sp = spots; s_cap = capacity;
        s_as = assigned_slot; s_go = gate_open; s_fl = full;
        checks++;
        if (!(grant[lane] | reject[lane])) begin
            errors++;
            $display("FAIL ack_wait lane %0d: no ack within %0d cycles, expected one", lane, n);
        end
        entry_req = '0;
        exit_req  = '0;
        if (s_g[lane] && clear_delay > 0) begin
            repeat (clear_delay - 1) @(negedge clk);
            gate_clear = 1'b1;
            @(negedge clk);
            gate_clear = 1'b0;
            repeat (CLOSE_C) @(negedge clk);
        end
    endtask

    int order[4];
    int n_ack;
    int n;

    initial begin
        reset = 1'b0; entry_req = '0; exit_req = '0; exit_slot = '0; gate_clear = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cap", 32'(capacity), 32'd4);
        chk("rst_spots", 32'(spots), 32'd0);
        chk("rst_open", 32'(gate_open), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        reset = 1'b1;

        do_req(0, 0, 3);
        chk("t1_grant", 32'(s_g), 32'b0001);
        chk("t1_spots", 32'(s_sp), 32'b0001);
        chk("t1_cap", 32'(s_cap), 32'd3);
        chk("t1_slot", 32'(s_as), 32'd0);
        chk("t1_open", 32'(s_go), 32'd1);

        gate_clear = 1'b1;
        @(negedge clk);
        gate_clear = 1'b0;
        @(negedge clk);
        chk("idle_clear_spots", 32'(spots), 32'b0001);

        do_req(0, 0, 1);
        do_req(0, 0, 1);
        do_req(0, 0, 1);
        chk("fill_spots", 32'(s_sp), 32'b1111);
        chk("fill_slot", 32'(s_as), 32'd3);
        do_req(1, 0, 0);
        chk("full_reject", 32'(s_r), 32'b0010);
        chk("full_grant", 32'(s_g), 32'b0000);
        chk("full_flag", 32'(s_fl), 32'd1);
        chk("full_cap", 32'(s_cap), 32'd0);
        chk("full_open", 32'(s_go), 32'd0);

        do_req(3, 1, 1);
        chk("x1_grant", 32'(s_g), 32'b1000);
        chk("x1_spots", 32'(s_sp), 32'b1101);
        do_req(3, 3, 1);
        chk("x2_spots", 32'(s_sp), 32'b0101);
        do_req(2, 1, 0);
        chk("xrej1", 32'(s_r), 32'b0100);
        do_req(2, 1, 0);
        chk("xrej2", 32'(s_r), 32'b0100);
        do_req(2, 2, 1);
        chk("x3_grant", 32'(s_g), 32'b0100);
        chk("x3_spots", 32'(s_sp), 32'b0001);
        chk("x3_cap", 32'(s_cap), 32'd3);
        chk("x3_slot", 32'(s_as), 32'd2);

        do_req(0, 0, 0);
        chk("to_slot", 32'(s_as), 32'd1);
        n = 0;
        while (gate_open === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("to_open_cycles", 32'(n), 32'd8);
        chk("to_pulse", 32'(timeout), 32'd1);
        chk("to_spots", 32'(spots), 32'b0001);
        chk("to_cap", 32'(capacity), 32'd3);
        repeat (CLOSE_C) @(negedge clk);

        do_req(0, 0, 0);
        repeat (7) @(negedge clk);
        gate_clear = 1'b1;
        @(negedge clk);
        gate_clear = 1'b0;
        chk("tie_timeout", 32'(timeout), 32'd0);
        chk("tie_spots", 32'(spots), 32'b0011);
        chk("tie_cap", 32'(capacity), 32'd2);
        repeat (CLOSE_C) @(negedge clk);

        do_req(0, 0, 0);
        chk("mr_spots_pre", 32'(s_sp), 32'b0111);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mr_open", 32'(gate_open), 32'd0);
        chk("mr_spots", 32'(spots), 32'd0);
        chk("mr_cap", 32'(capacity), 32'd4);
        chk("mr_timeout", 32'(timeout), 32'd0);
        reset = 1'b1;

        entry_req = 2'b11; exit_req = 2'b11; exit_slot = 4'b0100;
        n_ack = 0; n = 0;
        while (n_ack < 4 && n < 200) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < 4; i++) begin
                if ((grant[i] | reject[i]) && n_ack < 4) begin
                    order[n_ack] = i;
                    n_ack++;
                    if (i < 2) entry_req[i] = 1'b0;
                    else       exit_req[i - 2] = 1'b0;
                end
            end
            gate_clear = gate_open;
        end
        gate_clear = 1'b0;
        chk("rr_count", 32'(n_ack), 32'd4);
`ifdef EXIT_PRIORITY_EN
        chk("rr_0", 32'(order[0]), 32'd2);
        chk("rr_1", 32'(order[1]), 32'd3);
        chk("rr_2", 32'(order[2]), 32'd0);
        chk("rr_3", 32'(order[3]), 32'd1);
`else
        chk("rr_0", 32'(order[0]), 32'd0);
        chk("rr_1", 32'(order[1]), 32'd1);
        chk("rr_2", 32'(order[2]), 32'd2);
        chk("rr_3", 32'(order[3]), 32'd3);
`endif
        repeat (6) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parking_gate_arbiter.md
# parking_gate_arbiter

Shares one barrier gate and the slot pool of a NUM_SPOTS-slot lot among several entry and exit lanes. Each lane raises a request. The block arbitrates round-robin and either grants (allocating or freeing a slot and opening the gate) or rejects. It then sequences the gate through open, wait-for-clearance and closing phases. It sits between the lane sensors and the barrier actuator, and it is the only owner of occupancy state.

## Interface
- NUM_SPOTS, 4, number of parking slots
- N_ENTRY, 2, number of entry lanes
- N_EXIT, 2, number of exit lanes
- OPEN_CYCLES, 8, maximum cycles the gate stays open while waiting for gate_clear
- CLOSE_CYCLES, 2, cycles spent closing before the next arbitration
- Derived: R=N_ENTRY+N_EXIT; SLOT_W=$clog2(NUM_SPOTS); CAP_W=$clog2(NUM_SPOTS+1)

Ports (reset is synchronous, active-low; clock is clk):
- clk  in  1  clock
- reset  in  1  synchronous active-low reset
- entry_req  in  N_ENTRY  per-lane entry request, level, held until acknowledged
- exit_req  in  N_EXIT  per-lane exit request, level, held until acknowledged
- exit_slot  in  N_EXIT*SLOT_W  slot index per exit lane; lane j occupies bits [j*SLOT_W +: SLOT_W]
- gate_clear  in  1  vehicle-passed sensor pulse
- grant  out  R  one-hot, one-cycle acceptance pulse; entries occupy bits [N_ENTRY-1:0], exits the bits above
- reject  out  R  one-hot, one-cycle refusal pulse
- assigned_slot  out  SLOT_W  slot allocated or freed by the last grant
- gate_open  out  1  barrier open command
- timeout  out  1  one-cycle pulse when OPEN expires without gate_clear
- spots  out  NUM_SPOTS  occupancy; 1 means occupied
- capacity  out  CAP_W  count of free slots
- full  out  1  level; high when capacity==0

## Operation
- Reset values:
  - State IDLE; round-robin pointer 0.
  - grant=0, reject=0, timeout=0, gate_open=0, assigned_slot=0, spots=0.
  - capacity=NUM_SPOTS, full=0.
- Arbitration runs only in IDLE. The winner is the first request at or after the pointer, searching modulo R. At the decision edge:
  - An entry lane wins with capacity>0: grant. The lowest-index free slot is set in spots, capacity decrements, and assigned_slot takes that slot.
  - An entry lane wins with capacity==0: reject.
  - An exit lane wins and spots[exit_slot] is 1: grant. That bit clears, capacity increments, and assigned_slot takes exit_slot.
  - An exit lane wins and spots[exit_slot] is 0: reject.
  - After any grant or reject, the pointer becomes winner+1 mod R.
- After a grant, the block enters OPEN: gate_open=1 and the timer loads OPEN_CYCLES.
- After a reject, the block stays in IDLE and can arbitrate again on the next edge.
- OPEN:
  - The timer decrements on each edge.
  - gate_clear seen at an edge moves the block to CLOSE.
  - If the timer reaches 0 without gate_clear, the block pulses timeout and rolls back the allocation. An entry grant frees its slot again. An exit grant re-occupies its slot. capacity is restored to match. The block then moves to CLOSE.
- CLOSE: gate_open=0 for CLOSE_CYCLES cycles, then IDLE.
- gate_clear outside OPEN is ignored.
- Requests are ignored outside IDLE.
- A lane must drop its request in the cycle after its ack. A request dropped before its ack is simply not seen.
- capacity is always NUM_SPOTS minus popcount(spots). It never underflows and never exceeds NUM_SPOTS.

## Timing
- Latency from request to ack: a request sampled high at edge k produces grant/reject and the spots/capacity update visible after edge k. gate_open also rises after edge k.
- With no clearance, gate_open stays high for exactly OPEN_CYCLES cycles. timeout is high in the first CLOSE cycle.
- gate_clear at the same edge as timer expiry: clear wins and no rollback occurs.
- Minimum turnaround between two grants is 1 + CLOSE_CYCLES + the cycles spent in OPEN.
- Back-to-back rejects can occur on consecutive cycles.
- Reset mid-OPEN or mid-CLOSE: at the next edge every output returns to its reset value, including spots. No rollback pulse is issued.

## Configuration
- EXIT_PRIORITY_EN defined:
  - Any pending exit request beats all entry requests.
  - Exits use round-robin among themselves and entries use round-robin among themselves, each with its own pointer.
- EXIT_PRIORITY_EN undefined: a single round-robin pointer covers all R requesters.

## Structure
- Package parking_pkg:
  - gate_state_t enum {IDLE, OPEN, CLOSE}.
  - Slot and capacity width functions.
  - Default parameter constants.
- Sub-module rr_arbiter, parameterized by width:
  - Inputs: request vector and pointer.
  - Outputs: one-hot winner, valid, and next pointer.
  - Instantiated once without EXIT_PRIORITY_EN and twice with it.
- Lowest-free-slot search is a local priority encoder in parking_gate_arbiter.

## Test plan
- Reset, then entry_req=2'b01 → grant=4'b0001 after the next edge, spots=4'b0001, capacity=3, assigned_slot=0, gate_open=1. gate_clear 3 cycles later → gate_open=0 for 2 cycles, then IDLE.
- Fill all 4 slots, then entry_req=2'b10 → reject=4'b0010, full=1, capacity stays 0, gate_open stays 0.
- spots=4'b0101, exit lane 0 with exit_slot=1 → reject=4'b0100. Exit lane 0 with exit_slot=2 → grant=4'b0100, spots=4'b0001, capacity=3.
- Entry granted with no gate_clear → gate_open high for exactly 8 cycles, then timeout pulse. spots and capacity return to their pre-grant values.
- All four requests held continuously, each dropped after its own ack, without EXIT_PRIORITY_EN → acks arrive in order 0,1,2,3. With EXIT_PRIORITY_EN → order 2,3,0,1.
- Reset asserted in the 4th OPEN cycle → after the next edge gate_open=0, spots=0, capacity=4, timeout=0.
